debounce_edge: RTL

DEBOUNCE_EDGE -- requirements
Module: debounce_edge

---
 rtl/debounce_edge.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/debounce_edge.sv
// debounce_edge
//   Debounces a single already-synchronized input and reports the accepted
//   level together with one-cycle rise/fall pulses. A new level is accepted
//   only after STABLE_CYCLES consecutive samples that differ from the current
//   level. Runs that revert early are counted as glitches.
//
//   Optional feature macro: DEBOUNCE_GLITCH_CNT_EN
//     defined   -> glitch_cnt_o is a saturating 8-bit count of rejected runs
//     undefined -> no counter is built and glitch_cnt_o is tied to 8'd0
//
//   Parameters
//     STABLE_CYCLES  consecutive samples needed to accept a level (1..65535)
//     INIT_LEVEL     level_o value during and after reset
//
//   Ports
//     clk_i         in   1  clock, rising edge
//     rst_i         in   1  synchronous active-high reset
//     sig_i         in   1  synchronized input (may still bounce)
//     level_o       out  1  debounced level
//     rise_o        out  1  one-cycle pulse on level_o 0->1
//     fall_o        out  1  one-cycle pulse on level_o 1->0
//     glitch_cnt_o  out  8  count of rejected transitions
module debounce_edge #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sig_i,
  output logic       level_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic [7:0] glitch_cnt_o
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_e;

  // Compared against cnt+1 in 17 bits so the top legal value never wraps.
  localparam logic [16:0] TARGET    = 17'(STABLE_CYCLES);
  localparam state_e      RST_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        rise_q, rise_d;
  logic        fall_q, fall_d;
  logic [16:0] cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO, STABLE_HI: begin
        cnt_d = 16'd0;
        if (sig_i != level_q) begin
          if (STABLE_CYCLES == 1) begin
            // A single differing sample is already enough: flip directly.
            level_d = sig_i;
            rise_d  = sig_i;
            fall_d  = ~sig_i;
            if (sig_i) state_d = STABLE_HI;
            else       state_d = STABLE_LO;
          end else begin
            cnt_d = 16'd1;
            if (level_q) state_d = WAIT_LO;
            else         state_d = WAIT_HI;
          end
        end
      end
      WAIT_HI, WAIT_LO: begin
        if (sig_i == level_q) begin
          // Run broke before reaching STABLE_CYCLES: reject it.
          cnt_d = 16'd0;
          if (level_q) state_d = STABLE_HI;
          else         state_d = STABLE_LO;
        end else if (cnt_inc == TARGET) begin
          cnt_d   = 16'd0;
          level_d = sig_i;
          rise_d  = sig_i;
          fall_d  = ~sig_i;
          if (sig_i) state_d = STABLE_HI;
          else       state_d = STABLE_LO;
        end else begin
          cnt_d = cnt_inc[15:0];
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      cnt_q   <= 16'd0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       glitch_ev;
  logic [7:0] glitch_q;

  assign glitch_ev = ((state_q == WAIT_HI) || (state_q == WAIT_LO)) && (sig_i == level_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      glitch_q <= 8'd0;
    end else if (glitch_ev) begin
      glitch_q <= sat_inc8(glitch_q);
    end
  end

  assign glitch_cnt_o = glitch_q;
`else
  assign glitch_cnt_o = 8'd0;
`endif

endmodule
